wb_trace_buffer: RTL
====================

Name: wb_trace_buffer

Overview:
- Parametrised, synthesizable trace/capture unit for the 5-stage core.
- Replaces time-based register peeking in testbenches with an on-chip logic-analyser style buffer.
- Snoops two retire channels per cycle: register writeback (MEM_WB) and data-memory store (EX_MEM).
- Captures them into a circular buffer, freezes a programmable number of entries after a trigger match, and offers an indexed, registered readout port.

Parameters:
- XLEN, 32, data/address/PC width.
- DEPTH, 16, entry count; power of two, >= 4.
- POST_TRIG, 8, entries captured after the trigger entry before freeze; 0 <= POST_TRIG < DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  MEM_WB RegWrite with rd != 0.
- wb_rd  in  5  destination register index (reg_idx_t).
- wb_data  in  XLEN  writeback value.
- wb_pc  in  XLEN  PC of the writing instruction.
- st_valid  in  1  EX_MEM DataMem write.
- st_addr  in  XLEN  store address.
- st_data  in  XLEN  store data.
- st_pc  in  XLEN  PC of the store.
- trig_kind  in  2  TRIG_OFF=0, TRIG_KEY=1 (rd / address match), TRIG_PC=2, TRIG_DATA=3.
- trig_value  in  XLEN  compare value.
- clear  in  1  flush buffer and re-arm.
- rd_en  in  1  readout request.
- rd_idx  in  $clog2(DEPTH)  entry index, 0 = oldest.
- rd_entry  out  trace_entry_t  {ch, pc, key, data}; ch 0 = WB, 1 = ST; key = zero-extended rd or st_addr.
- rd_valid  out  1  rd_entry valid this cycle.
- rd_err  out  1  rd_idx >= count at request.
- count  out  $clog2(DEPTH)+1  entries held.
- state  out  2  ARMED / POST / FROZEN.
- triggered  out  1  sticky trigger seen.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, count=0, state=ARMED, triggered=0.
  - rd_valid=0, rd_err=0, rd_entry=0, post counter=POST_TRIG.
  - Buffer contents undefined; never readable, since count=0.
- Capture:
  - Each cycle in ARMED or POST, every valid channel writes one entry.
  - If both channels are valid, the WB entry is written at wr_ptr and the ST entry at wr_ptr+1 (WB is the older instruction). wr_ptr then advances by 2, otherwise by 1. All pointers wrap mod DEPTH.
  - count saturates at DEPTH. Once full, new writes overwrite the oldest entries, and the oldest pointer (wr_ptr - count) advances accordingly.
- Trigger match, per valid channel, only when state=ARMED and trig_kind != OFF:
  - KEY: key == trig_value.
  - PC: pc == trig_value.
  - DATA: data == trig_value.
- ARMED -> POST:
  - Occurs on a match on either channel; triggered<=1.
  - The matching entry is written and is not counted as post-trigger.
  - If both channels are valid and the WB entry matches, the ST entry in the same cycle counts as the first post entry.
- POST:
  - The post counter decrements by the number of entries written, excluding the trigger entry.
  - POST -> FROZEN when the counter would reach <= 0; all entries of that cycle are still written.
  - POST_TRIG=0: ARMED -> FROZEN directly in the trigger cycle.
- FROZEN: no writes, no state change until clear or rst.
- trig_kind=OFF: stays ARMED and runs as a continuous circular log.
- clear:
  - Same effect as rst except rd_* outputs are held.
  - Takes priority over same-cycle captures, which are dropped.
  - Same-cycle rd_en is still served from the pre-clear contents.
- Readout, one-cycle latency:
  - rd_en at edge N -> rd_valid=1 and rd_entry at edge N+1.
  - The read uses count and oldest pointer sampled before edge N's writes, so a simultaneous capture is not visible.
  - rd_idx >= count: rd_err=1, rd_entry=0, rd_valid=1.
  - rd_en=0: rd_valid=0, rd_entry held.
- Reads are legal in every state. Readout is deterministic only in FROZEN or TRIG_OFF with no live traffic.

Decomposition:
- Add to riscv_pkg:
  - trace_entry_t (packed struct: ch, pc, key, data).
  - trig_kind_e.
  - trace_state_e (ARMED=0, POST=1, FROZEN=2).
  - Channel constants CH_WB / CH_ST.
- One sub-module, trace_ram: DEPTH x trace_entry_t with two synchronous write ports (addr a, addr a+1) and one registered read port.
- The wrapper holds the pointers, count, FSM and trigger compare.

Test Plan:
- Single-channel fill, DEPTH=16, trig OFF: 20 WB writes with rd=1..20 and data=rd*3.
  - Expect count=16.
  - rd_idx 0 -> rd=5, data=15; rd_idx 15 -> rd=20, data=60.
- Dual-channel cycle: wb(rd=7, data=0x11) and st(addr=0x40, data=0x22) in the same cycle.
  - Expect idx 0 = ch 0, key 7; idx 1 = ch 1, key 0x40; count=2.
- Trigger, POST_TRIG=8, TRIG_KEY, trig_value=0x40:
  - 3 WB writes, then a store to 0x40, then 12 WB writes.
  - Expect FROZEN after 8 post entries, count=12.
  - Store entry at idx 3; later captures ignored.
- POST_TRIG=0 with TRIG_PC=0x24: the entry with pc 0x24 written at edge N.
  - Expect state=FROZEN and triggered=1 after edge N.
  - That entry is the newest, at idx count-1.
- Read past count: count=3, rd_idx=5.
  - Expect rd_valid=1, rd_err=1, rd_entry=0 one cycle later.
- Clear/reset mid-POST: clear and wb_valid in the same cycle.
  - Expect count=0, state=ARMED, triggered=0, no entry written.
  - Repeat with rst: identical, plus rd_valid=0.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the retire-trace capture unit: entry layout, trigger kinds,
// capture states and the trigger compare helper.
package wb_trace_buffer_pkg;

   localparam int TRACE_XLEN = 32;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic [1:0] {
      TRIG_OFF  = 2'd0,
      TRIG_KEY  = 2'd1,
      TRIG_PC   = 2'd2,
      TRIG_DATA = 2'd3
   } trig_kind_e;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      POST   = 2'd1,
      FROZEN = 2'd2
   } trace_state_e;

   localparam logic CH_WB = 1'b0;
   localparam logic CH_ST = 1'b1;

   typedef struct packed {
      logic                  ch;
      logic [TRACE_XLEN-1:0] pc;
      logic [TRACE_XLEN-1:0] key;
      logic [TRACE_XLEN-1:0] data;
   } trace_entry_t;

   function automatic logic trig_hit(input trig_kind_e kind, input trace_entry_t e,
                                     input logic [TRACE_XLEN-1:0] value);
      logic hit;
      hit = 1'b0;
      case (kind)
         TRIG_KEY:  hit = (e.key == value);
         TRIG_PC:   hit = (e.pc == value);
         TRIG_DATA: hit = (e.data == value);
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/wb_trace_buffer_trace_ram.sv
// Trace storage: two write ports at consecutive addresses (a, a+1) so a dual
// retire cycle lands in one edge, plus one registered read port.
module wb_trace_buffer_trace_ram
   import wb_trace_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  trace_entry_t  din_a,
   input  logic          we_b,
   input  trace_entry_t  din_b,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output trace_entry_t  dout
);

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] addr_b;

   assign addr_b = addr_a + AW'(1);

   // Reads sample the array before this edge's writes land.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
      if (re)   dout        <= mem[rd_addr];
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// Logic-analyser style capture of MEM_WB writebacks and EX_MEM stores into a
// circular buffer, frozen a fixed number of entries after a trigger match.
//
// state  | meaning
// ARMED  | logging, trigger compare active
// POST   | trigger seen, counting down post-trigger entries
// FROZEN | capture stopped, contents stable for readout
module wb_trace_buffer
   import wb_trace_buffer_pkg::*;
#(
   parameter int XLEN      = TRACE_XLEN,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  reg_idx_t                 wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic                     st_valid,
   input  logic [XLEN-1:0]          st_addr,
   input  logic [XLEN-1:0]          st_data,
   input  logic [XLEN-1:0]          st_pc,
   input  logic [1:0]               trig_kind,
   input  logic [XLEN-1:0]          trig_value,
   input  logic                     clear,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output trace_entry_t             rd_entry,
   output logic                     rd_valid,
   output logic                     rd_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic [1:0]               state,
   output logic                     triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   trace_state_e  st_q;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] cnt;
   logic [AW-1:0] post_cnt;
   logic          trig_q;
   logic          zero_q;

   trace_entry_t  wb_e, st_e, ram_q;
   trig_kind_e    kind;
   logic          capture, hit_wb, hit_st, rd_oob;
   logic [1:0]    n_wr, post_n;
   logic [CW-1:0] cnt_sum, cnt_nxt;
   logic [AW-1:0] oldest, rd_addr;

   assign kind = trig_kind_e'(trig_kind);
   assign wb_e = '{ch: CH_WB, pc: wb_pc, key: TRACE_XLEN'(wb_rd), data: wb_data};
   assign st_e = '{ch: CH_ST, pc: st_pc, key: st_addr, data: st_data};

   assign capture = (st_q != FROZEN) && !clear;
   assign n_wr    = {1'b0, wb_valid} + {1'b0, st_valid};
   assign hit_wb  = (st_q == ARMED) && wb_valid && trig_hit(kind, wb_e, trig_value);
   assign hit_st  = (st_q == ARMED) && st_valid && trig_hit(kind, st_e, trig_value);
   // A WB trigger makes the same-cycle store the first post entry; an ST
   // trigger is always the younger entry, so nothing after it this cycle.
   assign post_n  = hit_wb ? {1'b0, st_valid} : 2'd0;

   assign cnt_sum = cnt + CW'(n_wr);
   assign cnt_nxt = (cnt_sum > CW'(DEPTH)) ? CW'(DEPTH) : cnt_sum;

   // Full buffer has cnt[AW-1:0] == 0, so oldest collapses to wr_ptr.
   assign oldest  = wr_ptr - cnt[AW-1:0];
   assign rd_addr = oldest + rd_idx;
   assign rd_oob  = ({1'b0, rd_idx} >= cnt);

   wb_trace_buffer_trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_a    (capture && (wb_valid || st_valid)),
      .addr_a  (wr_ptr),
      .din_a   (wb_valid ? wb_e : st_e),
      .we_b    (capture && wb_valid && st_valid),
      .din_b   (st_e),
      .re      (rd_en),
      .rd_addr (rd_addr),
      .dout    (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ARMED;
         wr_ptr   <= '0;
         cnt      <= '0;
         post_cnt <= AW'(POST_TRIG);
         trig_q   <= 1'b0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         rd_valid <= rd_en;
         rd_err   <= rd_en && rd_oob;
         if (rd_en) zero_q <= rd_oob;

         if (clear) begin
            st_q     <= ARMED;
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= AW'(POST_TRIG);
            trig_q   <= 1'b0;
         end else if (capture) begin
            wr_ptr <= wr_ptr + AW'(n_wr);
            cnt    <= cnt_nxt;
            case (st_q)
               ARMED: begin
                  if (hit_wb || hit_st) begin
                     trig_q <= 1'b1;
                     if (AW'(post_n) >= post_cnt) begin
                        st_q <= FROZEN;
                     end else begin
                        st_q     <= POST;
                        post_cnt <= post_cnt - AW'(post_n);
                     end
                  end
               end
               POST: begin
                  if (AW'(n_wr) >= post_cnt) st_q <= FROZEN;
                  else post_cnt <= post_cnt - AW'(n_wr);
               end
               default: st_q <= st_q;
            endcase
         end
      end
   end

   assign rd_entry  = zero_q ? '0 : ram_q;
   assign count     = cnt;
   assign state     = st_q;
   assign triggered = trig_q;

endmodule
